// File: rtl/dns_pkg.sv
// dns_pkg: types and constants shared by the DNS responder slice.
//   dns_state_t : responder FSM state (IDLE, LOOKUP, RESPOND)
//   DNS_NAME_W / DNS_ADDR_W : default name-key and address widths
//   CNT_W       : width of the optional statistics counters
//   sat_inc     : saturating increment used by those counters
package dns_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    RESPOND = 2'd2
  } dns_state_t;

  localparam int DNS_NAME_W = 16;
  localparam int DNS_ADDR_W = 32;
  localparam int CNT_W      = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dns_table.sv
// dns_table: name->address storage for the DNS responder.
// Ports:
//   clk, reset         : clock, synchronous active-high reset (clears valid bits, pointer)
//   we_i               : write strobe (already qualified by the caller)
//   wname_i, waddr_i   : entry to write
//   ridx_i             : read index, driven from a register in the caller
//   rvalid_o, rname_o, raddr_o : contents of entry ridx_i
// Write placement: existing entry with the same name (lowest index) first,
// then the lowest-index free entry, otherwise the round-robin replacement slot.
module dns_table #(
  parameter int NAME_W = 16,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [NAME_W-1:0] wname_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output logic              rvalid_o,
  output logic [NAME_W-1:0] rname_o,
  output logic [ADDR_W-1:0] raddr_o
);

  logic [DEPTH-1:0]  valid_q;
  logic [NAME_W-1:0] name_q [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [IDX_W-1:0]  rptr_q, rptr_d;

  logic              hit_found, free_found;
  logic [IDX_W-1:0]  hit_idx, free_idx, widx;

  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit_found && valid_q[i] && (name_q[i] == wname_i)) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(i);
      end
      if (!free_found && !valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    widx   = hit_found ? hit_idx : (free_found ? free_idx : rptr_q);
    rptr_d = rptr_q;
    // DEPTH is a power of two, so the natural wrap of the pointer is DEPTH-1 -> 0.
    if (we_i && !hit_found && !free_found) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      rptr_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      if (we_i) valid_q[widx] <= 1'b1;
    end
  end

  // Names and addresses are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      name_q[widx] <= wname_i;
      addr_q[widx] <= waddr_i;
    end
  end

  assign rvalid_o = valid_q[ridx_i];
  assign rname_o  = name_q[ridx_i];
  assign raddr_o  = addr_q[ridx_i];

endmodule

// File: rtl/dns_responder.sv
// dns_responder: DNS-server side of the router's DNS request/response handshake.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   dns_req, query_name        : 4-phase request and name to resolve
//   dns_resp, resp_hit, resp_addr : response (held until dns_req drops); addr 0 on miss
//   upd_valid/upd_ready, upd_name, upd_addr : table write port (blocked during LOOKUP)
//   busy                       : FSM not idle
//   q_cnt, hit_cnt, miss_cnt, cancel_cnt : saturating statistics, present only
//                                when DNS_RESPONDER_STATS_EN is defined
// The lookup walks the table one entry per cycle; a dropped request cancels it.
module dns_responder
  import dns_pkg::*;
#(
  parameter int NAME_W = DNS_NAME_W,
  parameter int ADDR_W = DNS_ADDR_W,
  parameter int DEPTH  = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dns_req,
  input  logic [NAME_W-1:0] query_name,
  output logic              dns_resp,
  output logic              resp_hit,
  output logic [ADDR_W-1:0] resp_addr,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [NAME_W-1:0] upd_name,
  input  logic [ADDR_W-1:0] upd_addr,
`ifdef DNS_RESPONDER_STATS_EN
  output logic [CNT_W-1:0]  q_cnt,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  cancel_cnt,
`endif
  output logic              busy
);

  dns_state_t        state_q, state_d;
  logic [NAME_W-1:0] qname_q, qname_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              resp_q, resp_d;
  logic              hit_q, hit_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              ent_valid;
  logic [NAME_W-1:0] ent_name;
  logic [ADDR_W-1:0] ent_addr;

  assign upd_ready = (state_q != LOOKUP);

  dns_table #(
    .NAME_W (NAME_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .we_i     (upd_valid && upd_ready),
    .wname_i  (upd_name),
    .waddr_i  (upd_addr),
    .ridx_i   (idx_q),
    .rvalid_o (ent_valid),
    .rname_o  (ent_name),
    .raddr_o  (ent_addr)
  );

  always_comb begin
    state_d = state_q;
    qname_d = qname_q;
    idx_d   = idx_q;
    resp_d  = resp_q;
    hit_d   = hit_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (dns_req) begin
          qname_d = query_name;
          idx_d   = '0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        // Router cancel wins over a match found in the same cycle.
        if (!dns_req) begin
          state_d = IDLE;
        end else if (ent_valid && (ent_name == qname_q)) begin
          resp_d  = 1'b1;
          hit_d   = 1'b1;
          addr_d  = ent_addr;
          state_d = RESPOND;
        end else if (idx_q == IDX_W'(DEPTH - 1)) begin
          resp_d  = 1'b1;
          hit_d   = 1'b0;
          addr_d  = '0;
          state_d = RESPOND;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RESPOND: begin
        if (!dns_req) begin
          resp_d  = 1'b0;
          hit_d   = 1'b0;
          addr_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      resp_q  <= 1'b0;
      hit_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      hit_q   <= hit_d;
      addr_q  <= addr_d;
    end
  end

  // Query name and walk index are always rewritten on IDLE->LOOKUP before use.
  always_ff @(posedge clk) begin
    qname_q <= qname_d;
    idx_q   <= idx_d;
  end

  assign dns_resp  = resp_q;
  assign resp_hit  = hit_q;
  assign resp_addr = addr_q;
  assign busy      = (state_q != IDLE);

`ifdef DNS_RESPONDER_STATS_EN
  logic [CNT_W-1:0] q_cnt_q, hit_cnt_q, miss_cnt_q, cancel_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_cnt_q      <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      cancel_cnt_q <= '0;
    end else begin
      if (state_q == IDLE && state_d == LOOKUP) q_cnt_q <= sat_inc(q_cnt_q);
      if (state_q == LOOKUP && state_d == RESPOND) begin
        if (hit_d) hit_cnt_q  <= sat_inc(hit_cnt_q);
        else       miss_cnt_q <= sat_inc(miss_cnt_q);
      end
      if (state_q == LOOKUP && state_d == IDLE) cancel_cnt_q <= sat_inc(cancel_cnt_q);
    end
  end

  assign q_cnt      = q_cnt_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;
  assign cancel_cnt = cancel_cnt_q;
`endif

endmodule
